// File: rtl/piho_pkg.sv
// Shared definitions for the piho bin accumulator: FSM state encoding and
// default datapath widths.
package piho_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int SAMPLE_W = 64;
  localparam int BIN_W    = 80;
  localparam int BINS_W   = 16;
  localparam int LOG2_W   = 4;

  // Mask of a bin's sample index range: 2^log2 - 1.
  function automatic logic [BINS_W-1:0] bin_mask(input logic [LOG2_W-1:0] log2);
    return (BINS_W'(1) << log2) - BINS_W'(1);
  endfunction

endpackage

// File: rtl/piho_bin_outreg.sv
// Output holding register for completed bins: one-entry slot with a
// valid/ready handshake and detection of bins that arrive while it is full.
module piho_bin_outreg #(
  parameter int W = 80
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         drop
);

  // Handshake: data is transferred on a rising edge where valid && ready.
  // valid/data hold stable until then; a load arriving in the transfer
  // cycle replaces the slot so valid stays high, while a load arriving
  // with valid && !ready is discarded and flagged through drop.
  assign drop = load && valid && !ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && (!valid || ready)) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/piho_bin_accum.sv
// Bins per-sweep x2sum samples into sums of 2^bin_log2 samples and presents
// each bin through a valid/ready slot. Define PIHO_BIN_DROPCNT_EN to add the
// 'dropped' counter output.
module piho_bin_accum #(
  parameter int SAMPLE_W = piho_pkg::SAMPLE_W,
  parameter int BIN_W    = piho_pkg::BIN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  bin_log2,
  input  logic [15:0]                 total_bins,
  input  logic                        sample_valid,
  input  logic [SAMPLE_W-1:0]         sample,
  output logic                        bin_valid,
  input  logic                        bin_ready,
  output logic [BIN_W-1:0]            bin_sum,
  output logic [piho_pkg::BINS_W-1:0] bins_done,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
`ifdef PIHO_BIN_DROPCNT_EN
  ,
  output logic [15:0]                 dropped
`endif
);

  import piho_pkg::*;

  state_t              state_q;
  state_t              state_d;
  logic [3:0]          log2_q;
  logic [BINS_W-1:0]   total_q;
  logic [BIN_W-1:0]    acc_q;
  logic [BINS_W-1:0]   cnt_q;
  logic [BINS_W-1:0]   bins_q;
  logic                overrun_q;
  logic                start_ok;
  logic                accept;
  logic                bin_last;
  logic                drop;
  logic [BIN_W-1:0]    bin_total;

  assign start_ok  = start && (state_q != ST_ACCUM);
  assign accept    = (state_q == ST_ACCUM) && sample_valid;
  assign bin_last  = accept && (cnt_q == bin_mask(log2_q));
  assign bin_total = acc_q + {{(BIN_W-SAMPLE_W){1'b0}}, sample};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = (total_bins == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (bin_last && (bins_q + BINS_W'(1) == total_q)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ACCUM);
    done = (state_q == ST_DONE);
  end

  // Run parameters, accumulator and counters; a reset drops any partial bin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      log2_q    <= '0;
      total_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bins_q    <= '0;
      overrun_q <= 1'b0;
    end else if (start_ok) begin
      log2_q    <= bin_log2;
      total_q   <= total_bins;
      acc_q     <= '0;
      cnt_q     <= '0;
      bins_q    <= '0;
      overrun_q <= 1'b0;
    end else if (accept) begin
      if (bin_last) begin
        acc_q <= '0;
        cnt_q <= '0;
        if (bins_q != total_q) begin
          bins_q <= bins_q + BINS_W'(1);
        end
      end else begin
        acc_q <= bin_total;
        cnt_q <= cnt_q + BINS_W'(1);
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bins_done = bins_q;
  assign overrun   = overrun_q;

`ifdef PIHO_BIN_DROPCNT_EN
  logic [15:0] dropped_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dropped_q <= '0;
    end else if (start_ok) begin
      dropped_q <= '0;
    end else if (drop && (dropped_q != 16'hFFFF)) begin
      dropped_q <= dropped_q + 16'd1;
    end
  end

  assign dropped = dropped_q;
`endif

  piho_bin_outreg #(
    .W(BIN_W)
  ) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .load     (bin_last),
    .load_data(bin_total),
    .ready    (bin_ready),
    .valid    (bin_valid),
    .data     (bin_sum),
    .drop     (drop)
  );

endmodule

// File: tb/tb_piho_bin_accum.sv
// Self-checking bench for piho_bin_accum: directed scenarios plus random runs
// checked against a one-slot behavioural model and an expected-bin queue.
module tb_piho_bin_accum;

  localparam int SW = 64;
  localparam int BW = 80;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    bin_log2;
  logic [15:0]   total_bins;
  logic          sample_valid;
  logic [SW-1:0] sample;
  logic          bin_valid;
  logic          bin_ready;
  logic [BW-1:0] bin_sum;
  logic [15:0]   bins_done;
  logic          busy;
  logic          done;
  logic          overrun;
`ifdef PIHO_BIN_DROPCNT_EN
  logic [15:0]   dropped;
`endif

  always #5 clk = ~clk;

  piho_bin_accum dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bin_log2    (bin_log2),
    .total_bins  (total_bins),
    .sample_valid(sample_valid),
    .sample      (sample),
    .bin_valid   (bin_valid),
    .bin_ready   (bin_ready),
    .bin_sum     (bin_sum),
    .bins_done   (bins_done),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
`ifdef PIHO_BIN_DROPCNT_EN
    ,
    .dropped     (dropped)
`endif
  );

  int checks = 0;
  int passes = 0;
  logic [BW-1:0] exp_q[$];

  // Behavioural model: run bookkeeping plus a single presentation slot.
  bit            m_active = 0;
  bit            m_done = 0;
  int            m_size = 1;
  int            m_total = 0;
  int            m_cnt = 0;
  int            m_bins = 0;
  logic [BW-1:0] m_sum = '0;
  bit            m_over = 0;
  int            m_drop = 0;
  bit            m_pending = 0;
  logic [BW-1:0] m_held = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic r, input logic st, input logic [3:0] bl,
                            input logic [15:0] tb, input logic sv,
                            input logic [SW-1:0] s, input logic rdy);
    bit new_bin;
    logic [BW-1:0] nb;
    new_bin = 0;
    nb = '0;
    if (!r) begin
      m_active = 0; m_done = 0; m_cnt = 0; m_bins = 0; m_sum = '0;
      m_over = 0; m_drop = 0; m_pending = 0;
      exp_q.delete();
      return;
    end
    if (st && !m_active) begin
      m_size = 1 << bl; m_total = int'(tb); m_cnt = 0; m_bins = 0; m_sum = '0;
      m_over = 0; m_drop = 0;
      m_active = (tb != 0); m_done = (tb == 0);
    end else if (m_active && sv) begin
      m_sum = m_sum + BW'(s);
      m_cnt++;
      if (m_cnt == m_size) begin
        new_bin = 1; nb = m_sum; m_sum = '0; m_cnt = 0;
        if (m_bins < m_total) m_bins++;
        if (m_bins == m_total) begin m_active = 0; m_done = 1; end
      end
    end
    if (new_bin && m_pending && !rdy) begin
      m_over = 1;
      if (m_drop != 16'hFFFF) m_drop++;
    end else if (new_bin) begin
      exp_q.push_back(nb);
      m_pending = 1;
      m_held = nb;
    end else if (m_pending && rdy) begin
      m_pending = 0;
    end
  endtask

  // One clock: drive inputs after the previous edge, update the model at the edge.
  task automatic cyc(input logic r, input logic st, input logic [3:0] bl,
                     input logic [15:0] tb, input logic sv,
                     input logic [SW-1:0] s, input logic rdy);
    rst = r; start = st; bin_log2 = bl; total_bins = tb;
    sample_valid = sv; sample = s; bin_ready = rdy;
    @(posedge clk);
    model_edge(r, st, bl, tb, sv, s, rdy);
    #2;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1, 0, 4'd0, 16'd0, 0, '0, rdy);
  endtask

  task automatic go(input logic [3:0] bl, input logic [15:0] tb, input logic rdy);
    cyc(1, 1, bl, tb, 0, '0, rdy);
  endtask

  task automatic feed(input logic [SW-1:0] s, input logic rdy);
    cyc(1, 0, 4'd0, 16'd0, 1, s, rdy);
  endtask

  // Monitor: sampled mid-cycle, after outputs settle and before the next edge.
  always @(negedge clk) begin
    check("valid", 128'(bin_valid), 128'(m_pending));
    check("status", {busy, done, overrun, bins_done},
          {m_active, m_done, m_over, 16'(m_bins)});
    if (m_pending) check("held_sum", 128'(bin_sum), 128'(m_held));
`ifdef PIHO_BIN_DROPCNT_EN
    check("dropped", 128'(dropped), 128'(m_drop));
`endif
    if (bin_valid && bin_ready && rst) begin
      if (exp_q.size() == 0) check("unexpected_bin", 128'(bin_sum), 128'hX);
      else check("bin_sum", 128'(bin_sum), 128'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [SW-1:0] s;
    logic [3:0] bl;
    logic [15:0] tb;

    cyc(0, 0, 4'd0, 16'd0, 0, '0, 0);
    cyc(0, 0, 4'd0, 16'd0, 0, '0, 0);
    check("reset_sum", 128'(bin_sum), 128'd0);

    // 2^2-sample bins, three bins, samples 1..12
    go(4'd2, 16'd3, 1);
    for (int i = 1; i <= 12; i++) feed(SW'(i), 1);
    check("run1_done", {done, bins_done}, {1'b1, 16'd3});
    idle(3, 1);

    // one-sample bins, host stalled: second bin dropped
    go(4'd0, 16'd2, 0);
    feed(SW'(5), 0);
    feed(SW'(7), 0);
    idle(2, 0);
    check("stall_sum", 128'(bin_sum), 128'd5);
    check("stall_over", {overrun, bins_done}, {1'b1, 16'd2});
    idle(2, 1);

    // full-scale samples, 2-sample bins
    go(4'd1, 16'd2, 1);
    for (int i = 0; i < 4; i++) feed('1, 1);
    check("max_over", 128'(overrun), 128'd0);
    idle(3, 1);

    // empty run
    go(4'd3, 16'd0, 1);
    check("empty_done", {busy, done, bin_valid}, {1'b0, 1'b1, 1'b0});
    idle(3, 1);

    // reset abandons a partial bin
    go(4'd2, 16'd1, 1);
    for (int i = 0; i < 3; i++) feed(SW'(9), 1);
    cyc(0, 0, 4'd0, 16'd0, 0, '0, 1);
    check("rst_idle", {busy, done, bins_done}, {1'b0, 1'b0, 16'd0});
    go(4'd2, 16'd1, 0);
    for (int i = 0; i < 4; i++) feed(SW'(2), 0);
    check("rst_fresh_sum", 128'(bin_sum), 128'd8);
    idle(2, 1);

    // completion coincides with a handshake
    go(4'd0, 16'd3, 0);
    feed(SW'(3), 0);
    feed(SW'(4), 1);
    check("swap_sum", {bin_valid, bin_sum}, {1'b1, 80'd4});
    feed(SW'(5), 1);
    check("swap_over", 128'(overrun), 128'd0);
    idle(3, 1);

    // random runs
    for (int run = 0; run < 25; run++) begin
      bl = 4'($urandom_range(0, 3));
      tb = 16'($urandom_range(1, 6));
      go(bl, tb, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 800 && !m_done; c++) begin
        if ($urandom_range(0, 7) == 0) s = '1;
        else s = {$urandom, $urandom};
        cyc(1, $urandom_range(0, 30) == 0, 4'($urandom_range(0, 15)),
            16'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), s,
            $urandom_range(0, 3) != 0);
      end
      if (!m_done) check("run_timeout", 128'(done), 128'd1);
      idle(3, 1);
    end

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/piho_bin_accum.md
PIHO_BIN_ACCUM -- requirements
Module: piho_bin_accum

Interface
REQ-001 Parameter SAMPLE_W, default 64, width of the per-sweep x2sum sample.
REQ-002 Parameter BIN_W, default 80, width of the bin sum (SAMPLE_W + 16).
REQ-003 Port clk  input  1  single clock; all logic on the rising edge.
REQ-004 Port rst  input  1  synchronous, active-low reset (rst==0 resets).
REQ-005 Port start  input  1  one-cycle pulse that begins a run.
REQ-006 Port bin_log2  input  4  bin size = 2^bin_log2 samples; sampled at start.
REQ-007 Port total_bins  input  16  number of bins per run; sampled at start.
REQ-008 Port sample_valid  input  1  one-cycle strobe from the upstream Monte Carlo unit after each post-warmup sweep.
REQ-009 Port sample  input  SAMPLE_W  unsigned x2sum value qualified by sample_valid.
REQ-010 Port bin_valid  output  1  bin_sum is valid.
REQ-011 Port bin_ready  input  1  host consumes bin_sum.
REQ-012 Port bin_sum  output  BIN_W  sum of one bin's samples.
REQ-013 Port bins_done  output  16  bins completed in the current run, dropped bins included.
REQ-014 Port busy  output  1  high in ACCUM.
REQ-015 Port done  output  1  high in DONE.
REQ-016 Port overrun  output  1  sticky; at least one bin was dropped in the current run.

Function
REQ-017 FSM states: IDLE, ACCUM, DONE.
REQ-018 FSM transitions: IDLE->ACCUM on start with total_bins!=0; IDLE->DONE on start with total_bins==0; ACCUM->DONE when bins_done reaches total_bins; DONE->ACCUM or DONE->DONE on start, by the same rule as IDLE.
REQ-019 Start handling: start in ACCUM is ignored; on an accepted start, the block clears the accumulator, sample counter, bins_done and overrun.
REQ-020 Sample acceptance: a sample is accepted only in ACCUM with sample_valid=1; it is ignored in IDLE and DONE.
REQ-021 Accumulation: the accumulator adds the zero-extended sample, unsigned, in BIN_W bits; with these widths it cannot overflow.
REQ-022 Bin completion: a bin completes on the cycle its 2^bin_log2-th sample is accepted.
REQ-023 On bin completion, in the next cycle: bin_sum = acc + sample, bin_valid = 1, accumulator = 0, and bins_done increments.
REQ-024 Latency from the final sample strobe to bin_valid is 1 cycle; bin_log2=0 yields one bin per sample.
REQ-025 Handshake: bin_valid and bin_sum hold stable until the cycle in which bin_valid and bin_ready are both 1; bin_valid then deasserts unless a new bin loads in that same cycle.
REQ-026 Simultaneous bin completion and handshake: the new bin loads, bin_valid stays 1, and nothing is dropped.
REQ-027 Bin completion while bin_valid=1 and bin_ready=0: the new bin is discarded, the held bin_sum is unchanged, overrun is set, and bins_done still increments.
REQ-028 A bin pending at the end of a run remains presentable in DONE until it is consumed.
REQ-029 bins_done saturates at total_bins.

Reset
REQ-030 With rst==0 at a clock edge, the block returns to IDLE and clears the accumulator, sample counter, bins_done, bin_sum, bin_valid, overrun, busy, done and the drop counter; a reset during ACCUM abandons the partial bin.

Configuration
REQ-031 Macro PIHO_BIN_DROPCNT_EN defined: adds output port dropped (16 bits), which counts discarded bins, saturates at 0xFFFF, and clears on an accepted start and on reset.
REQ-032 Macro PIHO_BIN_DROPCNT_EN undefined: the dropped port and its counter are absent; all other behaviour is identical.

Structure
REQ-033 Shared package piho_pkg holds the FSM state enum, SAMPLE_W, BIN_W and the bins_done width constant.
REQ-034 One sub-module, piho_bin_outreg, implements the output holding register, the valid/ready handshake and the drop detection; the FSM, counters and accumulator stay in the top module.

Verification
REQ-035 bin_log2=2, total_bins=3, samples 1..12 one per cycle, bin_ready=1 -> bin_sum 10, 26, 42, each 1 cycle after samples 4, 8, 12; done asserts with bins_done=3.
REQ-036 bin_log2=0, total_bins=2, bin_ready=0, samples 5 then 7 -> bin_sum stays 5, overrun=1, bins_done=2, dropped=1 if enabled.
REQ-037 bin_log2=1, bin_ready=1 held, back-to-back samples 0xFFFF_FFFF_FFFF_FFFF x4 -> bin_sum 0x1_FFFF_FFFF_FFFF_FFFE twice, no overrun.
REQ-038 Start with total_bins=0 -> DONE in the next cycle, bin_valid never asserts.
REQ-039 rst=0 during ACCUM after 3 of 4 samples, then a fresh start and 4 samples of 2 -> bin_sum 8, with no residue from before the reset.
REQ-040 Bin completes in the same cycle as bin_ready=1 while a bin is held -> new bin_sum presented next cycle, bin_valid continuous, overrun=0.
